// File: rtl/button_debounce_sync_pkg.sv
// Shared types and constants for the button debouncer: FSM state encoding and the
// default stability window for the 100 MHz board clock.
package button_debounce_sync_pkg;

  // 10 ms at 100 MHz.
  localparam int unsigned DefaultStableCount = 1_000_000;

  typedef enum logic [1:0] {
    StLow     = 2'b00,
    StRising  = 2'b01,
    StHigh    = 2'b11,
    StFalling = 2'b10
  } deb_state_e;

  // Debounced level carried by each state: the output only moves once a transition completes.
  function automatic logic state_level(deb_state_e st);
    return (st == StHigh) || (st == StFalling);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both flops clear on rst_ni.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debounce_sync.sv
// Debounces a raw asynchronous button into a clean clk_i-synchronous level plus a rise strobe.
// Optional DEBOUNCE_FALL_PULSE_EN adds a fall_o strobe on each completed 1->0 transition.
module button_debounce_sync
  import button_debounce_sync_pkg::*;
#(
  parameter int unsigned StableCount = DefaultStableCount
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic out_o,
  output logic rise_o
`ifdef DEBOUNCE_FALL_PULSE_EN
  ,
  output logic fall_o
`endif
);

  localparam int unsigned CntWidth = $clog2(StableCount + 1);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(StableCount - 1);

  logic                in_sync;
  deb_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                rise_q, rise_d;

  sync_2ff u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (in_i),
    .q_o    (in_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    unique case (state_q)
      StLow: begin
        if (in_sync) begin
          // A one-cycle window completes on the first differing sample.
          if (StableCount == 1) begin
            state_d = StHigh;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = StRising;
            cnt_d   = CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StRising: begin
        if (!in_sync) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHigh: begin
        if (!in_sync) begin
          if (StableCount == 1) begin
            state_d = StLow;
            cnt_d   = '0;
          end else begin
            state_d = StFalling;
            cnt_d   = CntOne;
          end
        end else begin
          cnt_d = '0;
        end
      end
      StFalling: begin
        if (in_sync) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StLow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StLow;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign out_o  = state_level(state_q);
  assign rise_o = rise_q;

`ifdef DEBOUNCE_FALL_PULSE_EN
  logic fall_q, fall_d;

  // Any completed release lands in StLow from one of the high-level states.
  assign fall_d = state_level(state_q) && (state_d == StLow);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign fall_o = fall_q;
`endif

endmodule
